gal_sop_prog: RTL and testbench

- Run-time programmable sum-of-products stage for FPGA emulation of mapped GAL netlists.
- Sits directly upstream of a GAL_OLMC and drives its A input.
- Its product-term table has the same semantics as the GAL_SOP TABLE parameter. The table is loaded serially from a fuse stream instead of being fixed at elaboration.
- The registered SOP result feeds the OLMC. The block adds one pipeline stage.

---
 rtl/gal_sop_prog.sv | 199 +++++++++++++++++++
 tb/tb_gal_sop_prog.sv | 371 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gal_sop_prog.sv
// gal_sop_prog
// -----------------------------------------------------------------------------
// Run-time programmable sum-of-products stage used when emulating mapped GAL
// netlists on an FPGA. It sits directly in front of a GAL_OLMC and drives that
// cell's A input. The product-term table uses GAL_SOP TABLE semantics, but it
// is loaded serially from a fuse stream instead of being fixed at elaboration.
// The SOP result is registered, so the block adds one pipeline stage.
//
// Fuse encoding, per input i of term t, pair {p,n}:
//   10 = A[i], 01 = ~A[i], 00 = input ignored, 11 = term forced 0.
//   A term whose pairs are all 00 evaluates to 1. SOP = OR of all terms.
// Stream order: term 0 first; within a term, input 0 first; p before n.
// Fuse bit k of the stream lands in fuse_map[k]. For term t and input i,
// p is at index 2*(t*WIDTH+i) and n is at index 2*(t*WIDTH+i)+1.
//
// Optional build macro: GAL_SOP_PARITY_EN
//   When defined, one even-parity bit follows the NFUSE table bits. A mismatch
//   returns the block to UNCONF with ERR set. When undefined, ERR is tied 0.
//
// Ports:
//   C          clock; all state updates on the rising edge
//   RN         synchronous active-low reset
//   A          SOP inputs (WIDTH bits)
//   Y          registered SOP result, goes to the OLMC A input
//   CFG_START  one-cycle pulse that begins a table load
//   CFG_VALID  CFG_DATA holds a fuse bit
//   CFG_DATA   serial fuse bit
//   CFG_READY  block accepts a fuse bit this cycle
//   DONE       table loaded; block in RUN
//   ERR        parity load error (parity build only)
// -----------------------------------------------------------------------------
module gal_sop_prog #(
    parameter int WIDTH = 2,
    parameter int DEPTH = 2,
    parameter int NFUSE = 2 * WIDTH * DEPTH
) (
    input  logic             C,
    input  logic             RN,
    input  logic [WIDTH-1:0] A,
    output logic             Y,
    input  logic             CFG_START,
    input  logic             CFG_VALID,
    input  logic             CFG_DATA,
    output logic             CFG_READY,
    output logic             DONE,
    output logic             ERR
);

    localparam int            CW       = $clog2(NFUSE + 1);
    localparam logic [CW-1:0] LAST_IDX = CW'(NFUSE - 1);

`ifdef GAL_SOP_PARITY_EN
    typedef enum logic [1:0] {
        UNCONF = 2'd0,
        LOAD   = 2'd1,
        RUN    = 2'd2,
        PARITY = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        UNCONF = 2'd0,
        LOAD   = 2'd1,
        RUN    = 2'd2
    } state_t;
`endif

    state_t           state;
    state_t           state_n;
    logic [CW-1:0]    count;
    logic [CW-1:0]    count_n;
    logic [NFUSE-1:0] fuse_map;
    logic [NFUSE-1:0] fuse_n;
    logic             sop_p0;
    logic             y_p1;
`ifdef GAL_SOP_PARITY_EN
    logic             err;
    logic             err_set;
`endif

    // Evaluate the OR of all product terms for the given fuse map and inputs.
    function automatic logic sop_eval(input logic [NFUSE-1:0] f,
                                      input logic [WIDTH-1:0] a);
        logic hit;
        logic term;
        logic p;
        logic n;
        hit = 1'b0;
        for (int t = 0; t < DEPTH; t++) begin
            term = 1'b1;
            for (int i = 0; i < WIDTH; i++) begin
                p = f[2*(t*WIDTH+i)];
                n = f[2*(t*WIDTH+i)+1];
                case ({p, n})
                    2'b10:   term = term & a[i];
                    2'b01:   term = term & ~a[i];
                    2'b11:   term = 1'b0;
                    default: term = term;   // 00: input does not participate
                endcase
            end
            hit = hit | term;
        end
        return hit;
    endfunction

    // Stage p0: combinational SOP of the current inputs.
    assign sop_p0 = sop_eval(fuse_map, A);

    // Next-state logic. CFG_START has priority over everything, so a fuse bit
    // presented in the same cycle as CFG_START is dropped.
    always_comb begin
        state_n = state;
        count_n = count;
        fuse_n  = fuse_map;
`ifdef GAL_SOP_PARITY_EN
        err_set = 1'b0;
`endif
        if (CFG_START) begin
            state_n = LOAD;
            count_n = '0;
        end else begin
            case (state)
                LOAD: begin
                    if (CFG_VALID) begin
                        // Decoded write; avoids indexing with the wider counter.
                        for (int k = 0; k < NFUSE; k++) begin
                            if (count == CW'(k)) begin
                                fuse_n[k] = CFG_DATA;
                            end
                        end
                        if (count == LAST_IDX) begin
                            count_n = '0;
`ifdef GAL_SOP_PARITY_EN
                            state_n = PARITY;
`else
                            state_n = RUN;
`endif
                        end else begin
                            count_n = count + CW'(1);
                        end
                    end
                end
`ifdef GAL_SOP_PARITY_EN
                PARITY: begin
                    // The table is complete here, so its XOR is final.
                    if (CFG_VALID) begin
                        if (CFG_DATA == ^fuse_map) begin
                            state_n = RUN;
                        end else begin
                            state_n = UNCONF;
                            err_set = 1'b1;
                        end
                    end
                end
`endif
                UNCONF:  state_n = UNCONF;
                RUN:     state_n = RUN;
                default: state_n = UNCONF;
            endcase
        end
    end

    // Stage p1: state, load bookkeeping and the registered SOP output.
    // Y is held at 0 outside RUN, and also on the START edge that leaves RUN.
    always_ff @(posedge C) begin
        if (!RN) begin
            state    <= UNCONF;
            count    <= '0;
            fuse_map <= '1;
            y_p1     <= 1'b0;
        end else begin
            state    <= state_n;
            count    <= count_n;
            fuse_map <= fuse_n;
            y_p1     <= (state == RUN && !CFG_START) ? sop_p0 : 1'b0;
        end
    end

`ifdef GAL_SOP_PARITY_EN
    // ERR is sticky until reset or the next CFG_START.
    always_ff @(posedge C) begin
        if (!RN) begin
            err <= 1'b0;
        end else if (CFG_START) begin
            err <= 1'b0;
        end else if (err_set) begin
            err <= 1'b1;
        end
    end
    assign ERR       = err;
    assign CFG_READY = (state == LOAD) || (state == PARITY);
`else
    assign ERR       = 1'b0;
    assign CFG_READY = (state == LOAD);
`endif

    assign DONE = (state == RUN);
    assign Y    = y_p1;

endmodule

// File: tb/tb_gal_sop_prog.sv
// Testbench for gal_sop_prog (WIDTH=2, DEPTH=2). A behavioural model holds
// the loaded fuse list as an array and evaluates each product term from its
// fuse pairs. Directed scenarios are followed by a randomized run that
// includes resets, restarts and stalls.
module tb_gal_sop_prog;

    localparam int WIDTH = 2;
    localparam int DEPTH = 2;
    localparam int NFUSE = 2 * WIDTH * DEPTH;
`ifdef GAL_SOP_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif
    localparam int LOADLEN = NFUSE + (PAR ? 1 : 0);

    // Stream bit k is vector bit k.
    localparam logic [NFUSE-1:0] S_MAIN   = 8'b0101_1001; // 1,0,0,1,1,0,1,0
    localparam logic [NFUSE-1:0] S_RELOAD = 8'b0000_0101; // 1,0,1,0,0,0,0,0

    logic             C = 1'b0;
    logic             RN = 1'b0;
    logic [WIDTH-1:0] A = '0;
    logic             CFG_START = 1'b0;
    logic             CFG_VALID = 1'b0;
    logic             CFG_DATA = 1'b0;
    logic             Y;
    logic             CFG_READY;
    logic             DONE;
    logic             ERR;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: 0 = unconfigured, 1 = loading, 2 = running, 3 = awaiting parity
    int m_mode = 0;
    int m_cnt  = 0;
    bit m_fuse[NFUSE];
    bit m_y    = 1'b0;
    bit m_err  = 1'b0;

    always #5 C = ~C;

    gal_sop_prog #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .C(C), .RN(RN), .A(A), .Y(Y),
        .CFG_START(CFG_START), .CFG_VALID(CFG_VALID), .CFG_DATA(CFG_DATA),
        .CFG_READY(CFG_READY), .DONE(DONE), .ERR(ERR)
    );

    // A term is true unless one of its fuses forbids the current input value:
    // the p fuse forbids A[i]=0, the n fuse forbids A[i]=1.
    function automatic bit ref_sop(input logic [WIDTH-1:0] a);
        bit any_term;
        bit ok;
        any_term = 1'b0;
        for (int t = 0; t < DEPTH; t++) begin
            ok = 1'b1;
            for (int i = 0; i < WIDTH; i++) begin
                if (m_fuse[2*(t*WIDTH+i)]   && !a[i]) ok = 1'b0;
                if (m_fuse[2*(t*WIDTH+i)+1] &&  a[i]) ok = 1'b0;
            end
            any_term = any_term | ok;
        end
        return any_term;
    endfunction

    function automatic bit fuse_xor();
        bit x;
        x = 1'b0;
        for (int k = 0; k < NFUSE; k++) x = x ^ m_fuse[k];
        return x;
    endfunction

    function automatic logic sbit(input logic [NFUSE-1:0] s, input int k);
        logic [NFUSE-1:0] v;
        v = s;
        if (k < NFUSE) return v[k];
        return ^v;
    endfunction

    // Advance the model with the inputs as they stand at the coming edge,
    // then let the edge happen and settle 1 time unit past it.
    task automatic tick();
        bit y_nx;
        if (!RN) begin
            m_mode = 0;
            m_cnt  = 0;
            for (int k = 0; k < NFUSE; k++) m_fuse[k] = 1'b1;
            m_y   = 1'b0;
            m_err = 1'b0;
        end else begin
            y_nx = (m_mode == 2 && !CFG_START) ? ref_sop(A) : 1'b0;
            if (CFG_START) begin
                m_mode = 1;
                m_cnt  = 0;
                m_err  = 1'b0;
            end else if (m_mode == 1 && CFG_VALID) begin
                m_fuse[m_cnt] = CFG_DATA;
                m_cnt++;
                if (m_cnt == NFUSE) begin
                    m_cnt  = 0;
                    m_mode = PAR ? 3 : 2;
                end
            end else if (m_mode == 3 && CFG_VALID) begin
                if (CFG_DATA == fuse_xor()) m_mode = 2;
                else begin
                    m_mode = 0;
                    m_err  = 1'b1;
                end
            end
            m_y = y_nx;
        end
        @(posedge C);
        #1;
    endtask

    task automatic send_bit(input logic b);
        CFG_VALID = 1'b1;
        CFG_DATA  = b;
        tick();
        CFG_VALID = 1'b0;
    endtask

    task automatic start_pulse();
        CFG_START = 1'b1;
        tick();
        CFG_START = 1'b0;
    endtask

    task automatic load(input logic [NFUSE-1:0] s, input int stall_at, input int stall_len);
        start_pulse();
        for (int k = 0; k < LOADLEN; k++) begin
            if (k == stall_at) begin
                CFG_VALID = 1'b0;
                repeat (stall_len) tick();
            end
            send_bit(sbit(s, k));
        end
    endtask

    task automatic test_reset();
        RN = 1'b0;
        tick();
        tick();
        RN = 1'b1;
        tick();
        n_checks++;
        if (Y !== 1'b0 || DONE !== 1'b0 || CFG_READY !== 1'b0 || ERR !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: Y=%b DONE=%b READY=%b ERR=%b required 0 0 0 0",
                     Y, DONE, CFG_READY, ERR);
        end
        for (int k = 0; k < 4; k++) begin
            A = WIDTH'($urandom_range(3, 0));
            tick();
            n_checks++;
            if (Y !== 1'b0 || DONE !== 1'b0) begin
                n_fail++;
                $display("FAIL idle_toggle: Y=%b DONE=%b required 0 0", Y, DONE);
            end
        end
    endtask

    task automatic test_load_run();
        logic [WIDTH-1:0] pat [3];
        logic             exp [3];
        pat = '{2'b01, 2'b10, 2'b11};
        exp = '{1'b1, 1'b0, 1'b1};
        load(S_MAIN, -1, 0);
        n_checks++;
        if (DONE !== 1'b1 || CFG_READY !== 1'b0) begin
            n_fail++;
            $display("FAIL load_done: DONE=%b READY=%b required 1 0", DONE, CFG_READY);
        end
        for (int k = 0; k < 3; k++) begin
            A = pat[k];
            tick();
            n_checks++;
            if (Y !== exp[k] || Y !== m_y) begin
                n_fail++;
                $display("FAIL run_y A=%b: Y=%b required %b (model %b)", A, Y, exp[k], m_y);
            end
        end
    endtask

    task automatic test_stall();
        load(S_MAIN, 3, 5);
        n_checks++;
        if (DONE !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_done: DONE=%b required 1", DONE);
        end
        for (int k = 0; k < 4; k++) begin
            A = WIDTH'(k);
            tick();
            n_checks++;
            if (Y !== A[0]) begin
                n_fail++;
                $display("FAIL stall_y A=%b: Y=%b required %b", A, Y, A[0]);
            end
        end
    endtask

    task automatic test_edge_terms();
        load('0, -1, 0);
        for (int k = 0; k < 4; k++) begin
            A = WIDTH'($urandom_range(3, 0));
            tick();
            n_checks++;
            if (Y !== 1'b1) begin
                n_fail++;
                $display("FAIL all_zero_y A=%b: Y=%b required 1", A, Y);
            end
        end
        load('1, -1, 0);
        for (int k = 0; k < 4; k++) begin
            A = WIDTH'($urandom_range(3, 0));
            tick();
            n_checks++;
            if (Y !== 1'b0) begin
                n_fail++;
                $display("FAIL all_one_y A=%b: Y=%b required 0", A, Y);
            end
        end
    endtask

    task automatic test_reload_collision();
        load(S_MAIN, -1, 0);
        A = 2'b01;
        tick();
        n_checks++;
        if (Y !== 1'b1) begin
            n_fail++;
            $display("FAIL pre_reload_y: Y=%b required 1", Y);
        end
        CFG_START = 1'b1;
        CFG_VALID = 1'b1;
        CFG_DATA  = 1'b0;
        tick();
        CFG_START = 1'b0;
        CFG_VALID = 1'b0;
        n_checks++;
        if (Y !== 1'b0 || DONE !== 1'b0 || CFG_READY !== 1'b1) begin
            n_fail++;
            $display("FAIL restart_in_run: Y=%b DONE=%b READY=%b required 0 0 1",
                     Y, DONE, CFG_READY);
        end
        for (int k = 0; k < LOADLEN - 1; k++) send_bit(sbit(S_RELOAD, k));
        n_checks++;
        if (DONE !== 1'b0) begin
            n_fail++;
            $display("FAIL start_bit_discarded: DONE=%b required 0", DONE);
        end
        send_bit(sbit(S_RELOAD, LOADLEN - 1));
        n_checks++;
        if (DONE !== 1'b1) begin
            n_fail++;
            $display("FAIL reload_done: DONE=%b required 1", DONE);
        end
        for (int k = 0; k < 4; k++) begin
            A = WIDTH'(k);
            tick();
            n_checks++;
            if (Y !== 1'b1 || Y !== m_y) begin
                n_fail++;
                $display("FAIL reload_y A=%b: Y=%b required 1", A, Y);
            end
        end
    endtask

    task automatic test_reset_midload();
        start_pulse();
        for (int k = 0; k < 4; k++) send_bit(sbit(S_MAIN, k));
        RN = 1'b0;
        tick();
        RN = 1'b1;
        n_checks++;
        if (CFG_READY !== 1'b0 || DONE !== 1'b0 || Y !== 1'b0) begin
            n_fail++;
            $display("FAIL midload_reset: READY=%b DONE=%b Y=%b required 0 0 0",
                     CFG_READY, DONE, Y);
        end
        send_bit(1'b1);
        n_checks++;
        if (CFG_READY !== 1'b0 || DONE !== 1'b0) begin
            n_fail++;
            $display("FAIL unconf_ignores_bits: READY=%b DONE=%b required 0 0", CFG_READY, DONE);
        end
        start_pulse();
        for (int k = 0; k < LOADLEN - 1; k++) send_bit(sbit(S_MAIN, k));
        n_checks++;
        if (DONE !== 1'b0) begin
            n_fail++;
            $display("FAIL midload_full_len: DONE=%b required 0", DONE);
        end
        send_bit(sbit(S_MAIN, LOADLEN - 1));
        A = 2'b11;
        tick();
        n_checks++;
        if (DONE !== 1'b1 || Y !== 1'b1) begin
            n_fail++;
            $display("FAIL midload_reload: DONE=%b Y=%b required 1 1", DONE, Y);
        end
    endtask

`ifdef GAL_SOP_PARITY_EN
    task automatic test_parity();
        load(S_MAIN, -1, 0);
        n_checks++;
        if (DONE !== 1'b1 || ERR !== 1'b0) begin
            n_fail++;
            $display("FAIL parity_good: DONE=%b ERR=%b required 1 0", DONE, ERR);
        end
        start_pulse();
        for (int k = 0; k < NFUSE; k++) send_bit(sbit(S_MAIN, k));
        send_bit(1'b1);
        A = 2'b01;
        tick();
        n_checks++;
        if (ERR !== 1'b1 || DONE !== 1'b0 || Y !== 1'b0) begin
            n_fail++;
            $display("FAIL parity_bad: ERR=%b DONE=%b Y=%b required 1 0 0", ERR, DONE, Y);
        end
        start_pulse();
        n_checks++;
        if (ERR !== 1'b0) begin
            n_fail++;
            $display("FAIL parity_err_clear: ERR=%b required 0", ERR);
        end
    endtask
`endif

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            RN        = ($urandom_range(99, 0) >= 2);
            CFG_START = ($urandom_range(99, 0) < 4);
            CFG_VALID = ($urandom_range(99, 0) < 60);
            CFG_DATA  = 1'($urandom_range(1, 0));
            A         = WIDTH'($urandom_range(3, 0));
            tick();
            n_checks++;
            if (Y !== m_y || DONE !== (m_mode == 2) ||
                CFG_READY !== (m_mode == 1 || m_mode == 3) || ERR !== m_err) begin
                n_fail++;
                $display("FAIL random_c%0d: Y=%b DONE=%b READY=%b ERR=%b required %b %b %b %b",
                         c, Y, DONE, CFG_READY, ERR, m_y, (m_mode == 2),
                         (m_mode == 1 || m_mode == 3), m_err);
            end
        end
        RN        = 1'b1;
        CFG_START = 1'b0;
        CFG_VALID = 1'b0;
    endtask

    initial begin
        for (int k = 0; k < NFUSE; k++) m_fuse[k] = 1'b1;
        test_reset();
        test_load_run();
        test_stall();
        test_edge_terms();
        test_reload_collision();
        test_reset_midload();
`ifdef GAL_SOP_PARITY_EN
        test_parity();
`endif
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
